// File: rtl/mem_wb_if.sv
// ---------------------------------------------------------------------------
// mem_wb_if
// Bundles the MEM-stage inputs and the writeback/forwarding outputs of the
// MEM/WB pipeline register.
//   slave  : the MEM/WB stage (consumes MEM fields, drives writeback outputs)
//   master : the surrounding pipeline (drives MEM fields, consumes outputs)
// MEM side : w_valid_in, w_reg_wr_in, w_wb_sel_in, w_ld_size_in,
//            w_ld_unsigned_in, w_byte_off_in, w_alu_in, w_mem_in, w_link_in,
//            w_dst_in, w_stall, w_flush
// WB side  : w_rf_wr_en, w_rf_addr, w_rf_data, w_fwd_valid, w_fwd_addr,
//            w_fwd_data, w_misalign, w_retire_cnt
// ---------------------------------------------------------------------------
interface mem_wb_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic              w_valid_in;
  logic              w_reg_wr_in;
  logic [1:0]        w_wb_sel_in;
  logic [1:0]        w_ld_size_in;
  logic              w_ld_unsigned_in;
  logic [1:0]        w_byte_off_in;
  logic [DWIDTH-1:0] w_alu_in;
  logic [DWIDTH-1:0] w_mem_in;
  logic [DWIDTH-1:0] w_link_in;
  logic [AWIDTH-1:0] w_dst_in;
  logic              w_stall;
  logic              w_flush;

  logic              w_rf_wr_en;
  logic [AWIDTH-1:0] w_rf_addr;
  logic [DWIDTH-1:0] w_rf_data;
  logic              w_fwd_valid;
  logic [AWIDTH-1:0] w_fwd_addr;
  logic [DWIDTH-1:0] w_fwd_data;
  logic              w_misalign;
  logic [31:0]       w_retire_cnt;

  modport slave (
    input  w_valid_in, w_reg_wr_in, w_wb_sel_in, w_ld_size_in,
           w_ld_unsigned_in, w_byte_off_in, w_alu_in, w_mem_in, w_link_in,
           w_dst_in, w_stall, w_flush,
    output w_rf_wr_en, w_rf_addr, w_rf_data, w_fwd_valid, w_fwd_addr,
           w_fwd_data, w_misalign, w_retire_cnt
  );

  modport master (
    output w_valid_in, w_reg_wr_in, w_wb_sel_in, w_ld_size_in,
           w_ld_unsigned_in, w_byte_off_in, w_alu_in, w_mem_in, w_link_in,
           w_dst_in, w_stall, w_flush,
    input  w_rf_wr_en, w_rf_addr, w_rf_data, w_fwd_valid, w_fwd_addr,
           w_fwd_data, w_misalign, w_retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register and writeback unit. Captures the memory-stage
// result on the rising edge, selects the writeback source (ALU / load / link),
// extracts little-endian sub-word loads with sign or zero extension, flags
// misaligned loads (suppressing their write), and counts retired instructions.
// The registered result drives both the register-file write port and the
// forwarding outputs; all outputs come straight from flops.
// Ports:
//   w_clk  : clock, all state updates on posedge
//   r_rst  : asynchronous active-low reset
//   bus    : mem_wb_if.slave (MEM-stage fields in, writeback/forwarding out)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic    w_clk,
  input  logic    r_rst,
  mem_wb_if.slave bus
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;

  // Sub-word extraction; size 11 is treated as a full word.
  function automatic logic [DWIDTH-1:0] load_extract(
    input logic [DWIDTH-1:0] mem,
    input logic [1:0]        size,
    input logic              uns,
    input logic [1:0]        off
  );
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [DWIDTH-1:0]  r;
    b_s = mem[8*off +: 8];
    h_s = off[1] ? mem[31:16] : mem[15:0];
    case (size)
      SZ_BYTE: r = uns ? {{(DWIDTH-8){1'b0}}, b_s} : {{(DWIDTH-8){b_s[7]}}, b_s};
      SZ_HALF: r = uns ? {{(DWIDTH-16){1'b0}}, h_s} : {{(DWIDTH-16){h_s[15]}}, h_s};
      default: r = mem;
    endcase
    return r;
  endfunction

  // Halves need even offsets, words (and reserved size) need offset 0.
  function automatic logic load_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

  logic              rf_wr_en_q, rf_wr_en_d;
  logic [AWIDTH-1:0] rf_addr_q,  rf_addr_d;
  logic [DWIDTH-1:0] rf_data_q,  rf_data_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic              retire_inc;

  // MEM stage -> next writeback fields
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_addr_d    = bus.w_dst_in;
    rf_data_d    = '0;
    misalign_d   = 1'b0;
    retire_inc   = 1'b0;
    retire_cnt_d = retire_cnt_q;

    misalign_d = bus.w_valid_in && (bus.w_wb_sel_in == SEL_LOAD) &&
                 load_misaligned(bus.w_ld_size_in, bus.w_byte_off_in);

    case (bus.w_wb_sel_in)
      SEL_ALU:  rf_data_d = bus.w_alu_in;
      SEL_LOAD: rf_data_d = load_extract(bus.w_mem_in, bus.w_ld_size_in,
                                         bus.w_ld_unsigned_in, bus.w_byte_off_in);
      SEL_LINK: rf_data_d = bus.w_link_in;
      default:  rf_data_d = '0;
    endcase

    rf_wr_en_d = bus.w_valid_in && bus.w_reg_wr_in && (bus.w_wb_sel_in != 2'b11) &&
                 !misalign_d && (bus.w_dst_in != '0);

    // Every real instruction retires unless its load faulted; writes are not required.
    retire_inc   = bus.w_valid_in && !misalign_d;
    retire_cnt_d = retire_cnt_q + (retire_inc ? 32'd1 : 32'd0);
  end

  // MEM/WB register: flush > stall > load
  always_ff @(posedge w_clk or negedge r_rst) begin
    if (!r_rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      misalign_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else if (bus.w_flush) begin
      rf_wr_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      misalign_q   <= 1'b0;
    end else if (!bus.w_stall) begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      misalign_q   <= misalign_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // WB stage -> register file and forwarding network (same registered values)
  assign bus.w_rf_wr_en   = rf_wr_en_q;
  assign bus.w_rf_addr    = rf_addr_q;
  assign bus.w_rf_data    = rf_data_q;
  assign bus.w_fwd_valid  = rf_wr_en_q;
  assign bus.w_fwd_addr   = rf_addr_q;
  assign bus.w_fwd_data   = rf_data_q;
  assign bus.w_misalign   = misalign_q;
  assign bus.w_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed testbench for mem_wb_stage: ALU writeback, sub-word loads,
// misaligned loads, $0 writes, reserved select, stall/flush, asynchronous
// reset mid-operation and retire-counter wrap.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mem_wb_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

  mem_wb_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .w_clk (clk),
    .r_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full output check; forwarding outputs are compared with the same expectations.
  task automatic expect_all(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic mis, input logic [31:0] cnt);
    chk({tag, ".rf_wr_en"}, {31'b0, bus.w_rf_wr_en}, {31'b0, en});
    chk({tag, ".rf_addr"},  {27'b0, bus.w_rf_addr},  {27'b0, addr});
    chk({tag, ".rf_data"},  bus.w_rf_data,           data);
    chk({tag, ".fwd_valid"},{31'b0, bus.w_fwd_valid},{31'b0, en});
    chk({tag, ".fwd_addr"}, {27'b0, bus.w_fwd_addr}, {27'b0, addr});
    chk({tag, ".fwd_data"}, bus.w_fwd_data,          data);
    chk({tag, ".misalign"}, {31'b0, bus.w_misalign}, {31'b0, mis});
    chk({tag, ".retire"},   bus.w_retire_cnt,        cnt);
  endtask

  // Check only enable, misalign and counter (data unspecified when suppressed).
  task automatic expect_ctl(input string tag, input logic en, input logic mis,
                            input logic [31:0] cnt);
    chk({tag, ".rf_wr_en"}, {31'b0, bus.w_rf_wr_en}, {31'b0, en});
    chk({tag, ".fwd_valid"},{31'b0, bus.w_fwd_valid},{31'b0, en});
    chk({tag, ".misalign"}, {31'b0, bus.w_misalign}, {31'b0, mis});
    chk({tag, ".retire"},   bus.w_retire_cnt,        cnt);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [1:0] sz, input logic uns, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] link, input logic [4:0] dst);
    bus.w_valid_in       = v;
    bus.w_reg_wr_in      = rw;
    bus.w_wb_sel_in      = sel;
    bus.w_ld_size_in     = sz;
    bus.w_ld_unsigned_in = uns;
    bus.w_byte_off_in    = off;
    bus.w_alu_in         = alu;
    bus.w_mem_in         = mem;
    bus.w_link_in        = link;
    bus.w_dst_in         = dst;
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    bus.w_stall = 1'b0;
    bus.w_flush = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd1);

    // Reset state (valid input present, must be ignored while reset held)
    cyc();
    cyc();
    expect_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    #2 rst_n = 1'b1;

    // ALU writeback
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 5'd9);
    cyc();
    expect_all("alu", 1'b1, 5'd9, 32'h1234_5678, 1'b0, 32'd1);

    // Sub-word loads from 0x80FF7F01
    drive(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd3);
    cyc();
    expect_all("lb3", 1'b1, 5'd3, 32'hFFFF_FF80, 1'b0, 32'd2);
    drive(1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd3);
    cyc();
    expect_all("lbu3", 1'b1, 5'd3, 32'h0000_0080, 1'b0, 32'd3);
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 5'd4);
    cyc();
    expect_all("lh2", 1'b1, 5'd4, 32'hFFFF_80FF, 1'b0, 32'd4);
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0, 5'd4);
    cyc();
    expect_all("lhu0", 1'b1, 5'd4, 32'h0000_7F01, 1'b0, 32'd5);
    drive(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 5'd4);
    cyc();
    expect_all("lb1", 1'b1, 5'd4, 32'h0000_007F, 1'b0, 32'd6);

    // Link writeback
    drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'd0, 32'h1, 32'h2, 32'h0040_0008, 5'd31);
    cyc();
    expect_all("link", 1'b1, 5'd31, 32'h0040_0008, 1'b0, 32'd7);

    // Misaligned word load: write suppressed, one-cycle pulse, not counted
    drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 5'd4);
    cyc();
    expect_ctl("lw_mis", 1'b0, 1'b1, 32'd7);

    // ALU write to $0: no write, but counted; misalign pulse ends
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_AAAA, 32'h0, 32'h0, 5'd0);
    cyc();
    expect_ctl("dst0", 1'b0, 1'b0, 32'd8);

    // Reserved select: no write, data 0, still retires
    drive(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'd0, 32'h1111_1111, 32'h0, 32'h0, 5'd5);
    cyc();
    expect_all("sel11", 1'b0, 5'd5, 32'h0, 1'b0, 32'd9);

    // Misaligned half held through a stall, then cleared by a bubble
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 5'd6);
    cyc();
    expect_ctl("lh_mis", 1'b0, 1'b1, 32'd9);
    bus.w_stall = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h2222_2222, 32'h0, 32'h0, 5'd2);
    cyc();
    expect_ctl("lh_mis_stall", 1'b0, 1'b1, 32'd9);
    bus.w_stall = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h2222_2222, 32'h0, 32'h0, 5'd2);
    cyc();
    expect_ctl("bubble", 1'b0, 1'b0, 32'd9);

    // Stall for three cycles with new inputs present: frozen
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd7);
    cyc();
    expect_all("pre_stall", 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, 32'd10);
    bus.w_stall = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h3333_3333, 32'h0, 32'h0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_all("stall", 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, 32'd10);
    end

    // Flush together with stall and a valid input: bubble, counter holds
    bus.w_flush = 1'b1;
    cyc();
    expect_all("flush", 1'b0, 5'd0, 32'h0, 1'b0, 32'd10);
    bus.w_flush = 1'b0;
    bus.w_stall = 1'b0;

    // Asynchronous reset mid-operation, with stall asserted
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd2);
    cyc();
    expect_all("pre_rst", 1'b1, 5'd2, 32'h0000_0055, 1'b0, 32'd11);
    bus.w_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    expect_all("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    cyc();
    expect_all("rst_held", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    #2 rst_n = 1'b1;
    bus.w_stall = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_0066, 32'h0, 32'h0, 5'd6);
    cyc();
    expect_all("post_rst", 1'b1, 5'd6, 32'h0000_0066, 1'b0, 32'd1);

    // Counter wrap
    bus.w_valid_in = 1'b0;
    cyc();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    chk("preload", bus.w_retire_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd10);
    cyc();
    expect_all("wrap", 1'b1, 5'd10, 32'h0000_0077, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
